// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared constants, enums and tail-mask helper for the ALU issue sequencer
// Provides datapath geometry (LENGTH, SUB_LENGTH, VLEN, NREGS and derived widths),
// the ALU mode and FSM state enums, and the last-slice lane mask function.
package alu_seq_pkg;

    localparam int LENGTH     = 32;
    localparam int SUB_LENGTH = 8;
    localparam int VLEN       = 256;
    localparam int NREGS      = 32;

    localparam int LANES    = LENGTH / SUB_LENGTH;
    localparam int LANE_LOG = $clog2(LANES);
    localparam int EW       = (($clog2(LANE_LOG + 1) > 1) ? $clog2(LANE_LOG + 1) : 1) + 1;
    localparam int REGW     = $clog2(NREGS);
    localparam int VLW      = $clog2(VLEN / SUB_LENGTH) + 1;
    localparam int NSL      = VLEN / LENGTH;
    localparam int SLW      = (NSL > 1) ? $clog2(NSL) : 1;

    typedef enum logic [2:0] {
        MODE_ADD     = 3'd0,
        MODE_SUB     = 3'd1,
        MODE_OR      = 3'd2,
        MODE_AND     = 3'd3,
        MODE_NOT     = 3'd4,
        MODE_XOR     = 3'd5,
        MODE_MUL     = 3'd6,
        MODE_ILLEGAL = 3'd7
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN
    } state_e;

    // Each element of width SUB_LENGTH<<elen spans 2^elen lanes, so the last
    // slice enables the low (rem_elems << elen) lanes.
    function automatic logic [LANES-1:0] tail_mask(input logic [VLW-1:0] rem_elems,
                                                   input logic [EW-1:0]  elen);
        logic [LANES-1:0] m;
        int n;
        n = int'(rem_elems) << elen;
        for (int i = 0; i < LANES; i++) begin
            m[i] = (i < n);
        end
        return m;
    endfunction

endpackage

// File: rtl/alu_seq_lane_mask.sv
// rtl/alu_seq_lane_mask.sv - combinational lane enable for the final slice of an instruction
// Ports: rem_elems (elements left for the last slice), elen (element width code),
//        lane_en (one bit per SUB_LENGTH lane).
module alu_seq_lane_mask
    import alu_seq_pkg::*;
(
    input  logic [VLW-1:0]   rem_elems,
    input  logic [EW-1:0]    elen,
    output logic [LANES-1:0] lane_en
);

    assign lane_en = tail_mask(rem_elems, elen);

endmodule

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - slice-by-slice issue sequencer for the sliced SIMD ALU
// Ports: clk/rst; in_* instruction handshake; rf_rd_* register-file read port;
//        alu_* combinational ALU drive and alu_out result; wb_* write-back with
//        lane mask; done/err completion pulse.
module alu_sequencer
    import alu_seq_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_mode,
    input  logic [EW-1:0]     in_elen,
    input  logic [REGW-1:0]   in_vd,
    input  logic [REGW-1:0]   in_vs1,
    input  logic [REGW-1:0]   in_vs2,
    input  logic [VLW-1:0]    in_vl,
    output logic              rf_rd_en,
    output logic [REGW-1:0]   rf_rd_reg1,
    output logic [REGW-1:0]   rf_rd_reg2,
    output logic [SLW-1:0]    rf_rd_slice,
    input  logic [LENGTH-1:0] rf_rd_data1,
    input  logic [LENGTH-1:0] rf_rd_data2,
    output logic [2:0]        alu_mode,
    output logic [EW-1:0]     alu_elen,
    output logic [LENGTH-1:0] alu_op1,
    output logic [LENGTH-1:0] alu_op2,
    output logic              alu_carry_in,
    input  logic [LENGTH-1:0] alu_out,
    output logic              wb_valid,
    output logic [REGW-1:0]   wb_vd,
    output logic [SLW-1:0]    wb_slice,
    output logic [LENGTH-1:0] wb_data,
    output logic [LANES-1:0]  wb_lane_en,
    output logic              done,
    output logic              err
);

    state_e            state_q, state_d;
    logic [2:0]        mode_q, mode_d;
    logic [EW-1:0]     elen_q, elen_d;
    logic [REGW-1:0]   vd_q, vd_d, vs1_q, vs1_d, vs2_q, vs2_d;
    logic [SLW-1:0]    last_q, last_d, cnt_q, cnt_d;
    logic [VLW-1:0]    rem_q, rem_d;
    logic              ex_valid_q, ex_valid_d, ex_last_q, ex_last_d;
    logic [SLW-1:0]    ex_slice_q, ex_slice_d;
    logic              wb_valid_q, wb_valid_d;
    logic [REGW-1:0]   wb_vd_q, wb_vd_d;
    logic [SLW-1:0]    wb_slice_q, wb_slice_d;
    logic [LENGTH-1:0] wb_data_q, wb_data_d;
    logic [LANES-1:0]  wb_lane_q, wb_lane_d;
    logic              done_q, done_d, err_q, err_d;

    logic              illegal;
    logic [VLW-1:0]    vl_cap, vl_eff, lanes_used, full_lanes;
    logic [SLW-1:0]    acc_last;
    logic [LANES-1:0]  tail_lanes;

    // Accept-time geometry: lanes_used is the whole instruction measured in
    // SUB_LENGTH lanes; the last slice holds whatever remains past full slices.
    assign illegal    = (in_mode == MODE_ILLEGAL) || (in_elen > EW'(LANE_LOG));
    assign vl_cap     = VLW'(VLEN / SUB_LENGTH) >> in_elen;
    assign vl_eff     = (in_vl < vl_cap) ? in_vl : vl_cap;
    assign lanes_used = vl_eff << in_elen;
    assign acc_last   = SLW'((lanes_used - VLW'(1)) >> LANE_LOG);
    assign full_lanes = VLW'(acc_last) << LANE_LOG;

    alu_seq_lane_mask u_lane_mask (
        .rem_elems (rem_q),
        .elen      (elen_q),
        .lane_en   (tail_lanes)
    );

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        elen_d     = elen_q;
        vd_d       = vd_q;
        vs1_d      = vs1_q;
        vs2_d      = vs2_q;
        last_d     = last_q;
        rem_d      = rem_q;
        cnt_d      = cnt_q;
        ex_valid_d = 1'b0;
        ex_last_d  = 1'b0;
        ex_slice_d = '0;
        wb_valid_d = 1'b0;
        wb_vd_d    = '0;
        wb_slice_d = '0;
        wb_data_d  = '0;
        wb_lane_d  = '0;
        done_d     = 1'b0;
        err_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    mode_d = in_mode;
                    elen_d = in_elen;
                    vd_d   = in_vd;
                    vs1_d  = in_vs1;
                    vs2_d  = in_vs2;
                    last_d = acc_last;
                    rem_d  = (lanes_used - full_lanes) >> in_elen;
                    cnt_d  = '0;
                    if (illegal || (vl_eff == '0)) begin
                        state_d = ST_DRAIN;
                        done_d  = 1'b1;
                        err_d   = illegal;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                cnt_d      = cnt_q + SLW'(1);
                ex_valid_d = 1'b1;
                ex_slice_d = cnt_q;
                ex_last_d  = (cnt_q == last_q);
                if (cnt_q == last_q) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // done_q is the final write-back (or the reject pulse).
                if (done_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (ex_valid_q) begin
            wb_valid_d = 1'b1;
            wb_vd_d    = vd_q;
            wb_slice_d = ex_slice_q;
            wb_data_d  = alu_out;
            wb_lane_d  = ex_last_q ? tail_lanes : '1;
            if (ex_last_q) begin
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            mode_q     <= '0;
            elen_q     <= '0;
            vd_q       <= '0;
            vs1_q      <= '0;
            vs2_q      <= '0;
            last_q     <= '0;
            rem_q      <= '0;
            cnt_q      <= '0;
            ex_valid_q <= 1'b0;
            ex_last_q  <= 1'b0;
            ex_slice_q <= '0;
            wb_valid_q <= 1'b0;
            wb_vd_q    <= '0;
            wb_slice_q <= '0;
            wb_data_q  <= '0;
            wb_lane_q  <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            elen_q     <= elen_d;
            vd_q       <= vd_d;
            vs1_q      <= vs1_d;
            vs2_q      <= vs2_d;
            last_q     <= last_d;
            rem_q      <= rem_d;
            cnt_q      <= cnt_d;
            ex_valid_q <= ex_valid_d;
            ex_last_q  <= ex_last_d;
            ex_slice_q <= ex_slice_d;
            wb_valid_q <= wb_valid_d;
            wb_vd_q    <= wb_vd_d;
            wb_slice_q <= wb_slice_d;
            wb_data_q  <= wb_data_d;
            wb_lane_q  <= wb_lane_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign in_ready     = (state_q == ST_IDLE);
    assign rf_rd_en     = (state_q == ST_RUN);
    assign rf_rd_reg1   = rf_rd_en ? vs1_q : '0;
    assign rf_rd_reg2   = rf_rd_en ? vs2_q : '0;
    assign rf_rd_slice  = rf_rd_en ? cnt_q : '0;

    assign alu_mode     = ex_valid_q ? mode_q : '0;
    assign alu_elen     = ex_valid_q ? elen_q : '0;
    assign alu_op1      = ex_valid_q ? rf_rd_data1 : '0;
    assign alu_op2      = ex_valid_q ? rf_rd_data2 : '0;
    assign alu_carry_in = ex_valid_q && (mode_q == MODE_SUB);

    assign wb_valid     = wb_valid_q;
    assign wb_vd        = wb_vd_q;
    assign wb_slice     = wb_slice_q;
    assign wb_data      = wb_data_q;
    assign wb_lane_en   = wb_lane_q;
    assign done         = done_q;
    assign err          = err_q;

endmodule
